afifo_wr_ptr_full: RTL and testbench

//  Write-domain pointer and full-flag generator for the async FIFO. Sits upstream of
//    the dual-port RAM and the read-domain pointer logic.

---
 rtl/afifo_pkg.sv | 18 +
 rtl/code_convert_pkg.sv | 18 +
 rtl/gray_sync_ff.sv | 37 +++
 rtl/afifo_wr_ptr_full.sv | 99 +++++++++
 tb/tb_afifo_wr_ptr_full.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/afifo_pkg.sv
// Shared async-FIFO definitions for the write- and read-domain pointer blocks.
// Pointer types are ADDR_W dependent, so each block declares afifo_ptr_t locally.
package afifo_pkg;

  localparam int AFIFO_MIN_SYNC = 2;

  // The FIFO is full when the write gray pointer equals the read gray pointer
  // with its top two bits inverted. For ADDR_W=1, this inverts both bits.
  function automatic logic [7:0] gray_full_pattern(input logic [7:0]  g,
                                                   input int unsigned addr_w);
    logic [7:0] m;
    m           = '0;
    m[addr_w]   = 1'b1;
    m[addr_w-1] = 1'b1;
    return g ^ m;
  endfunction

endpackage

// File: rtl/code_convert_pkg.sv
// Binary/reflected-gray conversion on a fixed 8-bit width.
// Narrower codes are zero-extended before conversion.
package code_convert_pkg;

  function automatic logic [7:0] bin2grey(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] grey2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync_ff.sv
// Multi-flop synchroniser for a gray-coded bus crossing into the local clock.
// The read-domain pointer block uses the same module.
module gray_sync_ff #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [STAGES];
  logic [W-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/afifo_wr_ptr_full.sv
// Async FIFO write-domain pointer, RAM write port and pessimistic full flag.
// Optional occupancy estimate on wr_level when AFIFO_WR_LEVEL_EN is defined.
module afifo_wr_ptr_full
  import afifo_pkg::*;
  import code_convert_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              wr_en,
  output logic              wr_full,
  output logic              wr_overflow,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  input  logic [ADDR_W:0]   rd_ptr_gray_async
`ifdef AFIFO_WR_LEVEL_EN
  ,
  output logic [ADDR_W:0]   wr_level
`endif
);

  localparam int PW = ADDR_W + 1;
  typedef logic [PW-1:0] afifo_ptr_t;

  if (SYNC_STAGES < AFIFO_MIN_SYNC) begin : g_bad_sync
    $error("SYNC_STAGES must be at least AFIFO_MIN_SYNC");
  end

  afifo_ptr_t wbin_q, wbin_d;
  afifo_ptr_t wgray_q, wgray_d;
  afifo_ptr_t rq_sync;
  logic       full_q, full_d;
  logic       ovf_q, ovf_d;
  logic       push;
  logic [7:0] wgray8;

  gray_sync_ff #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_rq_sync (
    .clk (wclk),
    .rst (wrst),
    .d   (rd_ptr_gray_async),
    .q   (rq_sync)
  );

  // Full is computed from the next pointer, so it is high in the cycle the last push registers.
  always_comb begin
    push    = wr_en & ~full_q;
    wbin_d  = wbin_q + afifo_ptr_t'(push);
    wgray8  = bin2grey(8'(wbin_d));
    wgray_d = afifo_ptr_t'(wgray8);
    full_d  = (wgray8 == gray_full_pattern(8'(rq_sync), ADDR_W));
    ovf_d   = wr_en & full_q;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ram_we      = push;
  assign ram_waddr   = wbin_q[ADDR_W-1:0];
  assign wr_ptr_gray = wgray_q;
  assign wr_full     = full_q;
  assign wr_overflow = ovf_q;

`ifdef AFIFO_WR_LEVEL_EN
  afifo_ptr_t lvl_q, lvl_d;

  // The synchronised read pointer lags, so the level can overstate occupancy but never understate it.
  always_comb begin
    lvl_d = afifo_ptr_t'(8'(wbin_d) - grey2bin(8'(rq_sync)));
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      lvl_q <= '0;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  assign wr_level = lvl_q;
`endif

endmodule

// File: tb/tb_afifo_wr_ptr_full.sv
// Directed self-checking bench for afifo_wr_ptr_full (ADDR_W=3, SYNC_STAGES=2).
// Define AFIFO_WR_LEVEL_EN to also exercise wr_level.
module tb_afifo_wr_ptr_full;

  logic       wclk = 1'b0;
  logic       wrst = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_full, wr_overflow, ram_we;
  logic [2:0] ram_waddr;
  logic [3:0] wr_ptr_gray;
  logic [3:0] rd_ptr_gray_async = 4'b0000;
`ifdef AFIFO_WR_LEVEL_EN
  logic [3:0] wr_level;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  afifo_wr_ptr_full #(.ADDR_W(3), .SYNC_STAGES(2)) dut (
    .wclk              (wclk),
    .wrst              (wrst),
    .wr_en             (wr_en),
    .wr_full           (wr_full),
    .wr_overflow       (wr_overflow),
    .ram_we            (ram_we),
    .ram_waddr         (ram_waddr),
    .wr_ptr_gray       (wr_ptr_gray),
    .rd_ptr_gray_async (rd_ptr_gray_async)
`ifdef AFIFO_WR_LEVEL_EN
    ,
    .wr_level          (wr_level)
`endif
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [3:0] g4(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_full"}, wr_full, 0);
    check({tag, "_ovf"},  wr_overflow, 0);
    check({tag, "_addr"}, ram_waddr, 0);
    check({tag, "_gray"}, wr_ptr_gray, 0);
  endtask

  initial begin
    int         model;
    logic [3:0] prev;

    #2 wrst = 1'b1;
    #1;
    check_all_zero("reset");
    check("reset_we", ram_we, 0);
    tick();
    tick();
    wrst = 1'b0;

    // Test 1: reset in the middle of a push burst
    wr_en = 1'b1;
    repeat (5) tick();
    check("t1_pre_addr", ram_waddr, 5);
    check("t1_pre_gray", wr_ptr_gray, g4(5));
    wrst = 1'b1;
    #1;
    check_all_zero("t1_async");
    tick();
    check_all_zero("t1_held");
    wrst = 1'b0;
    #1;
    check("t1_we_after", ram_we, 1);

    // Test 2: eight pushes fill the FIFO
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_addr%0d", i), ram_waddr, i);
      check($sformatf("t2_we%0d", i), ram_we, 1);
      check($sformatf("t2_nfull%0d", i), wr_full, 0);
      tick();
    end
    check("t2_full", wr_full, 1);
    check("t2_gray", wr_ptr_gray, 4'b1100);

    // Test 3: push while full is dropped and flagged
    check("t3_we", ram_we, 0);
    check("t3_ovf_pre", wr_overflow, 0);
    tick();
    check("t3_ovf", wr_overflow, 1);
    check("t3_gray", wr_ptr_gray, 4'b1100);
    check("t3_addr", ram_waddr, 0);
    wr_en = 1'b0;
    tick();
    check("t3_ovf_clr", wr_overflow, 0);
    check("t3_full_hold", wr_full, 1);

    // Test 4: one read frees one slot after the sync latency
    rd_ptr_gray_async = 4'b0001;
    tick();
    check("t4_full_c1", wr_full, 1);
    tick();
    check("t4_full_c2", wr_full, 1);
    tick();
    check("t4_full_c3", wr_full, 0);
    wr_en = 1'b1;
    #1;
    check("t4_we", ram_we, 1);
    check("t4_addr", ram_waddr, 0);
    tick();
    wr_en = 1'b0;
    check("t4_refull", wr_full, 1);
    check("t4_gray", wr_ptr_gray, 4'b1101);

    // Test 5: long run through pointer wrap with the reader close behind
    model = 9;
    prev  = g4(model);
    rd_ptr_gray_async = g4(7);
    repeat (3) tick();
    check("t5_free", wr_full, 0);
    for (int i = 0; i < 19; i++) begin
      wr_en = 1'b1;
      #1;
      check($sformatf("t5_we%0d", i), ram_we, 1);
      check($sformatf("t5_nfull%0d", i), wr_full, 0);
      tick();
      model = (model + 1) % 16;
      check($sformatf("t5_gray%0d", i), wr_ptr_gray, g4(model));
      check($sformatf("t5_onebit%0d", i), $countones(wr_ptr_gray ^ prev), 1);
      prev = wr_ptr_gray;
      rd_ptr_gray_async = g4((model + 14) % 16);
    end
    wr_en = 1'b0;
    check("t5_addr_end", ram_waddr, 4);

`ifdef AFIFO_WR_LEVEL_EN
    // Test 6: occupancy estimate
    rd_ptr_gray_async = 4'b0000;
    wrst = 1'b1;
    #1;
    check("t6_lvl_rst", wr_level, 0);
    tick();
    wrst = 1'b0;
    wr_en = 1'b1;
    repeat (5) tick();
    wr_en = 1'b0;
    check("t6_lvl5", wr_level, 5);
    rd_ptr_gray_async = 4'b0011;
    tick();
    tick();
    check("t6_lvl_lag", wr_level, 5);
    tick();
    check("t6_lvl3", wr_level, 3);
    rd_ptr_gray_async = 4'b0000;
    repeat (3) tick();
    check("t6_lvl5b", wr_level, 5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
